cpu: RTL and testbench



---
 rtl/cpu.sv | 132 +++++++++++++
 tb/tb_cpu.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/cpu.sv
// ============================================================================
// cpu : 8-bit datapath with IR, 8x8 register file, ALU with carry/zero flags
//       and write-back mux, driven by an external control FSM.  Rev 1.0
// ============================================================================
`default_nettype none

module cpu_regfile (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       we_i,
   input  logic [2:0] waddr_i,
   input  logic [7:0] wdat_i,
   input  logic [2:0] raddr_a_i,
   input  logic [2:0] raddr_b_i,
   output logic [7:0] rdat_a_o,
   output logic [7:0] rdat_b_o
);
   logic [7:0] Mem [0:7];

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         for (int i = 0; i < 8; i++) Mem[i] <= '0;
      end else if (we_i) begin
         Mem[waddr_i] <= wdat_i;
      end
   end

   assign rdat_a_o = Mem[raddr_a_i];
   assign rdat_b_o = Mem[raddr_b_i];
endmodule

module cpu (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        clkEn_i,
   input  logic [17:0] inst_dat_i,
   input  logic        inst_ack_i,
   input  logic [7:0]  data_dat_i,
   input  logic [7:0]  port_dat_i,
   input  logic [1:0]  RegMux_c_i,
   input  logic        RegWrt_c_i,
   input  logic        op2_c_i,
   input  logic [3:0]  ALUOp_c_i,
   output logic [2:0]  op_o,
   output logic [2:0]  func_o,
   output logic [11:0] addr_o,
   output logic [7:0]  disp_o,
   output logic [7:0]  offset_o,
   output logic [7:0]  rs_o,
   output logic        carry_o,
   output logic        zero_o
);
   logic [17:0] ir_q;
   logic        carry_q, zero_q;
   logic [7:0]  w_a, w_rs2, w_b, w_imm, w_wb;
   logic [8:0]  w_alu;
   logic        w_we;
   logic        ir14_unused;

   assign w_imm       = ir_q[7:0];
   assign w_we        = clkEn_i & RegWrt_c_i;
   assign ir14_unused = ir_q[14];

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i)                     ir_q <= '0;
      else if (clkEn_i && inst_ack_i) ir_q <= inst_dat_i;
   end

   cpu_regfile MR (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .we_i      (w_we),
      .waddr_i   (ir_q[13:11]),
      .wdat_i    (w_wb),
      .raddr_a_i (ir_q[10:8]),
      .raddr_b_i (ir_q[7:5]),
      .rdat_a_o  (w_a),
      .rdat_b_o  (w_rs2)
   );

   assign w_b = op2_c_i ? w_rs2 : w_imm;

   // w_alu[8] is the carry-out for every op, including borrow and shifted-out bit
   always_comb begin
      w_alu = '0;
      case (ALUOp_c_i)
         4'b0000: w_alu = {1'b0, w_a} + {1'b0, w_b};
         4'b0001: w_alu = {1'b0, w_a} + {1'b0, w_b} + {8'd0, carry_q};
         4'b0010: w_alu = {1'b0, w_a} - {1'b0, w_b};
         4'b0011: w_alu = {1'b0, w_a} - {1'b0, w_b} - {8'd0, carry_q};
         4'b0100: w_alu = {1'b0, w_a & w_b};
         4'b0101: w_alu = {1'b0, w_a | w_b};
         4'b0110: w_alu = {1'b0, w_a ^ w_b};
         4'b0111: w_alu = {1'b0, w_b};
         4'b1000: w_alu = {w_a[7], w_a[6:0], 1'b0};
         4'b1001: w_alu = {w_a[0], 1'b0, w_a[7:1]};
         default: w_alu = '0;
      endcase
   end

   always_comb begin
      w_wb = w_alu[7:0];
      case (RegMux_c_i)
         2'b00:   w_wb = w_alu[7:0];
         2'b01:   w_wb = data_dat_i;
         2'b10:   w_wb = port_dat_i;
         default: w_wb = w_imm;
      endcase
   end

   // Flags move only with an ALU write-back so a steady ALUOp cannot disturb them
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         carry_q <= 1'b0;
         zero_q  <= 1'b0;
      end else if (w_we && (RegMux_c_i == 2'b00)) begin
         carry_q <= w_alu[8];
         zero_q  <= (w_alu[7:0] == 8'd0);
      end
   end

   assign op_o     = ir_q[17:15];
   assign func_o   = ir_q[2:0];
   assign addr_o   = ir_q[11:0];
   assign disp_o   = ir_q[7:0];
   assign offset_o = ir_q[7:0];
   assign rs_o     = w_a;
   assign carry_o  = carry_q;
   assign zero_o   = zero_q;
endmodule

`default_nettype wire

// File: tb/tb_cpu.sv
// ============================================================================
// tb_cpu : directed test plan plus random instructions checked against an
//          arithmetic reference model of the datapath.  Rev 1.0
// ============================================================================
`default_nettype none

module tb_cpu;
   logic        clk = 1'b0;
   logic        rst_i, clkEn_i, inst_ack_i, RegWrt_c_i, op2_c_i;
   logic [17:0] inst_dat_i;
   logic [7:0]  data_dat_i, port_dat_i;
   logic [1:0]  RegMux_c_i;
   logic [3:0]  ALUOp_c_i;
   logic [2:0]  op_o, func_o;
   logic [11:0] addr_o;
   logic [7:0]  disp_o, offset_o, rs_o;
   logic        carry_o, zero_o;

   int checks = 0;
   int errors = 0;
   int ref_mem [8];
   int ref_c, ref_z;
   logic [17:0] last_inst;

   cpu dut (
      .clk_i(clk), .rst_i(rst_i), .clkEn_i(clkEn_i),
      .inst_dat_i(inst_dat_i), .inst_ack_i(inst_ack_i),
      .data_dat_i(data_dat_i), .port_dat_i(port_dat_i),
      .RegMux_c_i(RegMux_c_i), .RegWrt_c_i(RegWrt_c_i),
      .op2_c_i(op2_c_i), .ALUOp_c_i(ALUOp_c_i),
      .op_o(op_o), .func_o(func_o), .addr_o(addr_o), .disp_o(disp_o),
      .offset_o(offset_o), .rs_o(rs_o), .carry_o(carry_o), .zero_o(zero_o)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, observed timeout expected $finish");
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   function automatic logic [17:0] rform(input logic [2:0] rd, rs, rs2, func);
      return {4'b1110, rd, rs, rs2, 2'b00, func};
   endfunction

   function automatic logic [17:0] iform(input logic [1:0] sub, input logic [2:0] rd, rs,
                                         input logic [7:0] imm);
      return {2'b00, sub, rd, rs, imm};
   endfunction

   // Load an instruction whose rs selects register k and check the read value
   task automatic rd_chk(input int k, input int exp);
      logic [17:0] inst;
      inst = rform(3'(k), 3'(k), 3'd0, 3'd0);
      inst_dat_i = inst; inst_ack_i = 1'b1; RegWrt_c_i = 1'b0;
      step();
      inst_ack_i = 1'b0;
      last_inst  = inst;
      chk($sformatf("R%0d", k), 32'(rs_o), 32'(exp));
   endtask

   task automatic exec(input logic [17:0] inst, input logic [3:0] op, input logic o2,
                       input logic [1:0] mux, input logic [7:0] dd, input logic [7:0] pd);
      int rd, rs, rs2, imm, a, b, r, c, val;
      rd = int'(inst[13:11]); rs = int'(inst[10:8]); rs2 = int'(inst[7:5]); imm = int'(inst[7:0]);
      a  = ref_mem[rs];
      b  = o2 ? ref_mem[rs2] : imm;
      case (op)
         4'd0:    begin r = a + b;          c = (r > 255) ? 1 : 0; end
         4'd1:    begin r = a + b + ref_c;  c = (r > 255) ? 1 : 0; end
         4'd2:    begin r = a - b;          c = (a < b) ? 1 : 0; end
         4'd3:    begin r = a - b - ref_c;  c = (a < b + ref_c) ? 1 : 0; end
         4'd4:    begin r = a & b;          c = 0; end
         4'd5:    begin r = a | b;          c = 0; end
         4'd6:    begin r = a ^ b;          c = 0; end
         4'd7:    begin r = b;              c = 0; end
         4'd8:    begin r = a * 2;          c = a / 128; end
         4'd9:    begin r = a / 2;          c = a % 2; end
         default: begin r = 0;              c = 0; end
      endcase
      r = r & 255;
      case (mux)
         2'd0:    val = r;
         2'd1:    val = int'(dd);
         2'd2:    val = int'(pd);
         default: val = imm;
      endcase
      // FETCH
      inst_dat_i = inst; inst_ack_i = 1'b1; RegWrt_c_i = 1'b0;
      step();
      last_inst = inst;
      chk("op", 32'(op_o), 32'(inst[17:15]));
      chk("func", 32'(func_o), 32'(inst[2:0]));
      chk("addr", 32'(addr_o), 32'(inst[11:0]));
      chk("disp", 32'(disp_o), 32'(inst[7:0]));
      chk("offset", 32'(offset_o), 32'(inst[7:0]));
      chk("rs", 32'(rs_o), 32'(a));
      // DECODE, EXECUTE
      inst_ack_i = 1'b0; ALUOp_c_i = op; op2_c_i = o2; RegMux_c_i = mux;
      data_dat_i = dd; port_dat_i = pd;
      step();
      step();
      // WRITEBACK
      RegWrt_c_i = 1'b1;
      step();
      RegWrt_c_i = 1'b0;
      ref_mem[rd] = val;
      if (mux == 2'd0) begin
         ref_c = c;
         ref_z = (r == 0) ? 1 : 0;
      end
      chk("carry", 32'(carry_o), 32'(ref_c));
      chk("zero", 32'(zero_o), 32'(ref_z));
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_op"}, 32'(op_o), 0);
      chk({tag, "_func"}, 32'(func_o), 0);
      chk({tag, "_addr"}, 32'(addr_o), 0);
      chk({tag, "_disp"}, 32'(disp_o), 0);
      chk({tag, "_offset"}, 32'(offset_o), 0);
      chk({tag, "_rs"}, 32'(rs_o), 0);
      chk({tag, "_carry"}, 32'(carry_o), 0);
      chk({tag, "_zero"}, 32'(zero_o), 0);
   endtask

   initial begin
      rst_i = 1'b0; clkEn_i = 1'b1; inst_ack_i = 1'b0; RegWrt_c_i = 1'b0;
      op2_c_i = 1'b0; ALUOp_c_i = 4'd0; RegMux_c_i = 2'd0;
      inst_dat_i = '0; data_dat_i = '0; port_dat_i = '0;
      for (int i = 0; i < 8; i++) ref_mem[i] = 0;
      ref_c = 0; ref_z = 0; last_inst = '0;
      #1;
      chk_all_zero("reset");
      step();
      step();
      rst_i = 1'b1;
      step();

      // Directed test plan
      exec(rform(3'd0, 3'd0, 3'd0, 3'd2), 4'd2, 1'b1, 2'd0, 8'h00, 8'h00);
      exec(iform(2'd0, 3'd1, 3'd0, 8'd100), 4'd0, 1'b0, 2'd0, 8'h00, 8'h00);
      exec(iform(2'd0, 3'd2, 3'd0, 8'd200), 4'd0, 1'b0, 2'd0, 8'h00, 8'h00);
      chk("addi_carry", 32'(carry_o), 0);
      rd_chk(1, 100);
      rd_chk(2, 200);
      exec(rform(3'd3, 3'd1, 3'd2, 3'd0), 4'd0, 1'b1, 2'd0, 8'h00, 8'h00);
      chk("add_carry", 32'(carry_o), 1);
      chk("add_zero", 32'(zero_o), 0);
      rd_chk(3, 8'h2C);
      exec(iform(2'd1, 3'd4, 3'd0, 8'd255), 4'd1, 1'b0, 2'd0, 8'h00, 8'h00);
      chk("addci_carry", 32'(carry_o), 1);
      chk("addci_zero", 32'(zero_o), 1);
      rd_chk(4, 0);
      exec(rform(3'd5, 3'd0, 3'd4, 3'd3), 4'd3, 1'b1, 2'd0, 8'h00, 8'h00);
      chk("subc1_carry", 32'(carry_o), 1);
      rd_chk(5, 8'hFF);
      exec(rform(3'd0, 3'd0, 3'd0, 3'd0), 4'd0, 1'b1, 2'd0, 8'h00, 8'h00);
      chk("add0_carry", 32'(carry_o), 0);
      chk("add0_zero", 32'(zero_o), 1);
      exec(rform(3'd5, 3'd0, 3'd4, 3'd3), 4'd3, 1'b1, 2'd0, 8'h00, 8'h00);
      chk("subc2_zero", 32'(zero_o), 1);
      rd_chk(5, 0);
      exec(iform(2'd2, 3'd0, 3'd5, 8'd255), 4'd2, 1'b0, 2'd0, 8'h00, 8'h00);
      chk("subi_carry", 32'(carry_o), 1);
      rd_chk(0, 1);
      exec(rform(3'd7, 3'd3, 3'd3, 3'd2), 4'd2, 1'b1, 2'd0, 8'h00, 8'h00);
      chk("sub_zero", 32'(zero_o), 1);
      chk("sub_carry", 32'(carry_o), 0);
      rd_chk(7, 0);

      // Random instructions against the reference model
      for (int n = 0; n < 80; n++) begin
         logic [17:0] inst;
         inst = 18'($urandom);
         exec(inst, 4'($urandom_range(0, 15)), 1'($urandom), 2'($urandom),
              8'($urandom), 8'($urandom));
         rd_chk(int'(inst[13:11]), ref_mem[inst[13:11]]);
      end

      // Clock-enable low freezes IR, registers and flags
      clkEn_i = 1'b0; inst_dat_i = ~last_inst; inst_ack_i = 1'b1;
      RegWrt_c_i = 1'b1; RegMux_c_i = 2'd1; data_dat_i = 8'hA5; ALUOp_c_i = 4'd0;
      step(); step(); step();
      chk("frz_op", 32'(op_o), 32'(last_inst[17:15]));
      chk("frz_addr", 32'(addr_o), 32'(last_inst[11:0]));
      chk("frz_rs", 32'(rs_o), 32'(ref_mem[last_inst[10:8]]));
      chk("frz_carry", 32'(carry_o), 32'(ref_c));
      chk("frz_zero", 32'(zero_o), 32'(ref_z));
      clkEn_i = 1'b1; inst_ack_i = 1'b0; RegWrt_c_i = 1'b0;
      for (int k = 0; k < 8; k++) rd_chk(k, ref_mem[k]);

      // Make flags nonzero, then reset in the middle of a write-back
      exec(rform(3'd6, 3'd6, 3'd6, 3'd0), 4'd8, 1'b1, 2'd3, 8'h00, 8'h00);
      exec(iform(2'd1, 3'd6, 3'd0, 8'h81), 4'd7, 1'b0, 2'd0, 8'h00, 8'h00);
      exec(rform(3'd6, 3'd6, 3'd6, 3'd0), 4'd8, 1'b1, 2'd0, 8'h00, 8'h00);
      chk("pre_rst_carry", 32'(carry_o), 1);
      inst_dat_i = iform(2'd0, 3'd1, 3'd6, 8'h5A); inst_ack_i = 1'b1;
      step();
      inst_ack_i = 1'b0; RegMux_c_i = 2'd3; ALUOp_c_i = 4'd0; op2_c_i = 1'b0;
      step();
      RegWrt_c_i = 1'b1;
      #2 rst_i = 1'b0;
      #1 chk_all_zero("rst_mid");
      @(posedge clk);
      @(negedge clk);
      RegWrt_c_i = 1'b0;
      rst_i = 1'b1;
      for (int i = 0; i < 8; i++) ref_mem[i] = 0;
      ref_c = 0; ref_z = 0;
      step();
      chk_all_zero("post_rst");
      for (int k = 0; k < 8; k++) rd_chk(k, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

`default_nettype wire
